// File: rtl/bcd_display_scan.sv
//----------------------------------------------------------------------------
// bcd_display_scan: multiplexed 7-segment driver for a BCD digit vector,
// with per-frame snapshot, leading-zero blanking and anode dead time.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module bcd_display_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS*5-1:0] digits_i,
  input  logic                  enable_i,
  input  logic                  blank_lz_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_DEAD    = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] C_IDX_MAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [N_DIGITS*5-1:0] snap_q, snap_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  last_idx;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   blank_vec;
  logic [4:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            cur_seg;

  assign tick     = (cnt_q == C_CNT_MAX);
  assign last_idx = (idx_q == C_IDX_MAX);

  // A digit is blanked when it and every more-significant digit is 0 without dp.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (snap_q[5*i +: 5] == 5'd0);
      blank_vec[i] = blank_lz_i && zero_run;
    end
  end

  always_comb begin
    cur_digit = snap_q[4:0];
    cur_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = snap_q[5*i +: 5];
        cur_blank = blank_vec[i];
      end
    end
  end

  always_comb begin
    case (cur_digit[4:1])
      4'd0:    cur_seg = 7'b1000000;
      4'd1:    cur_seg = 7'b1111001;
      4'd2:    cur_seg = 7'b0100100;
      4'd3:    cur_seg = 7'b0110000;
      4'd4:    cur_seg = 7'b0011001;
      4'd5:    cur_seg = 7'b0010010;
      4'd6:    cur_seg = 7'b0000010;
      4'd7:    cur_seg = 7'b1111000;
      4'd8:    cur_seg = 7'b0000000;
      4'd9:    cur_seg = 7'b0010000;
      default: cur_seg = 7'b0111111;
    endcase
  end

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = last_idx ? '0 : idx_q + IW'(1);
    end
    // Snapshot only at frame wrap so a frame never mixes two input values.
    snap_d  = (tick && last_idx) ? digits_i : snap_q;
    frame_d = tick && last_idx;

    an_d = '1;
    if (enable_i && (cnt_q >= C_DEAD) && !cur_blank) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = cur_blank ? 7'h7F : cur_seg;
    dp_d  = cur_blank ? 1'b1  : ~cur_digit[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
//----------------------------------------------------------------------------
// tb_bcd_display_scan: directed self-checking bench for bcd_display_scan.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_display_scan;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int DC = 2;

  localparam logic [3:0] AN_SEL   [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  localparam logic [6:0] SEG_4321 [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [19:0] D_4321 = {4'd4, 1'b0, 4'd3, 1'b0, 4'd2, 1'b0, 4'd1, 1'b0};
  localparam logic [19:0] D_9999 = {4'd9, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0};
  localparam logic [19:0] D_0050 = {4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0};
  localparam logic [19:0] D_0050P = {4'd0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0};
  localparam logic [19:0] D_00C0 = {4'd0, 1'b0, 4'd0, 1'b0, 4'hC, 1'b0, 4'd0, 1'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic [N*5-1:0] digits_i;
  logic          enable_i;
  logic          blank_lz_i;
  logic [N-1:0]  an_o;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic          frame_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bcd_display_scan #(
    .N_DIGITS   (N),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_i  (digits_i),
    .enable_i  (enable_i),
    .blank_lz_i(blank_lz_i),
    .an_o      (an_o),
    .seg_o     (seg_o),
    .dp_o      (dp_o),
    .frame_o   (frame_o)
  );

  // Output sampled at cyc=k reflects counter state from before clock edge k.
  function automatic int slot_of(int c);
    return ((c - 1) / RD) % N;
  endfunction

  function automatic int phase_of(int c);
    return (c - 1) % RD;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(int n);
    while (cyc < n) step();
  endtask

  task automatic test_reset();
    digits_i   = 20'($urandom);
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold got an=%h seg=%b dp=%b frame=%b exp an=f seg=1111111 dp=1 frame=0",
               an_o, seg_o, dp_o, frame_o);
    end
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests++;
      if (an_o !== ((cyc < 3) ? 4'hF : 4'hE)) begin
        fails++;
        $display("FAIL reset_release_an cyc=%0d got=%h exp=%h", cyc, an_o, (cyc < 3) ? 4'hF : 4'hE);
      end
    end
    run_to(12);
    tests++;
    if (an_o !== 4'hD || seg_o !== 7'b1000000) begin
      fails++;
      $display("FAIL pre_async got an=%h seg=%b exp an=d seg=1000000", an_o, seg_o);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_async got an=%h seg=%b dp=%b frame=%b exp an=f seg=1111111 dp=1 frame=0",
               an_o, seg_o, dp_o, frame_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    digits_i   = D_4321;
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      step();
      tests++;
      if (frame_o !== (cyc == 32)) begin
        fails++;
        $display("FAIL scan_first_frame cyc=%0d got=%b exp=%b", cyc, frame_o, cyc == 32);
      end
    end
    for (int k = 33; k <= 64; k++) begin
      step();
      exp_an = (phase_of(cyc) >= DC) ? AN_SEL[slot_of(cyc)] : 4'hF;
      tests++;
      if (an_o !== exp_an || seg_o !== SEG_4321[slot_of(cyc)] || dp_o !== 1'b1 ||
          frame_o !== (cyc == 64)) begin
        fails++;
        $display("FAIL scan cyc=%0d got an=%h seg=%b dp=%b frame=%b exp an=%h seg=%b dp=1 frame=%b",
                 cyc, an_o, seg_o, dp_o, frame_o, exp_an, SEG_4321[slot_of(cyc)], cyc == 64);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] exp_seg;
    for (int k = 65; k <= 128; k++) begin
      step();
      exp_seg = (cyc <= 96) ? SEG_4321[slot_of(cyc)] : 7'b0010000;
      tests++;
      if (seg_o !== exp_seg || frame_o !== (cyc % 32 == 0)) begin
        fails++;
        $display("FAIL snapshot cyc=%0d got seg=%b frame=%b exp seg=%b frame=%b",
                 cyc, seg_o, frame_o, exp_seg, cyc % 32 == 0);
      end
      if (cyc == 76) digits_i = D_9999;
    end
  endtask

  task automatic test_blanking();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         s;
    digits_i   = D_0050;
    enable_i   = 1'b1;
    blank_lz_i = 1'b1;
    do_reset();
    run_to(32);
    for (int k = 33; k <= 96; k++) begin
      step();
      s = slot_of(cyc);
      if (cyc <= 64 && s >= 2) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_an  = (phase_of(cyc) >= DC) ? AN_SEL[s] : 4'hF;
        exp_seg = (s == 1) ? 7'b0010010 : 7'b1000000;
        exp_dp  = (cyc > 64 && s == 3) ? 1'b0 : 1'b1;
      end
      tests++;
      if (an_o !== exp_an || seg_o !== exp_seg || dp_o !== exp_dp) begin
        fails++;
        $display("FAIL blanking cyc=%0d got an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b",
                 cyc, an_o, seg_o, dp_o, exp_an, exp_seg, exp_dp);
      end
      if (cyc == 50) digits_i = D_0050P;
    end
  endtask

  task automatic test_invalid();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         s;
    digits_i   = D_00C0;
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;
    do_reset();
    run_to(32);
    for (int k = 33; k <= 96; k++) begin
      step();
      s = slot_of(cyc);
      if (cyc <= 64) begin
        exp_an  = (phase_of(cyc) >= DC) ? AN_SEL[s] : 4'hF;
        exp_seg = (s == 1) ? 7'b0111111 : 7'b1000000;
      end else if (s == 0) begin
        exp_an  = (phase_of(cyc) >= DC) ? 4'hE : 4'hF;
        exp_seg = 7'b1000000;
      end else begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end
      tests++;
      if (an_o !== exp_an || seg_o !== exp_seg || dp_o !== 1'b1) begin
        fails++;
        $display("FAIL invalid cyc=%0d got an=%h seg=%b dp=%b exp an=%h seg=%b dp=1",
                 cyc, an_o, seg_o, dp_o, exp_an, exp_seg);
      end
      if (cyc == 45) digits_i = '0;
      if (cyc == 64) blank_lz_i = 1'b1;
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_an;
    digits_i   = D_4321;
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;
    do_reset();
    run_to(32);
    for (int k = 33; k <= 96; k++) begin
      step();
      if (cyc >= 41 && cyc <= 60) exp_an = 4'hF;
      else exp_an = (phase_of(cyc) >= DC) ? AN_SEL[slot_of(cyc)] : 4'hF;
      tests++;
      if (an_o !== exp_an || seg_o !== SEG_4321[slot_of(cyc)] || frame_o !== (cyc % 32 == 0)) begin
        fails++;
        $display("FAIL enable cyc=%0d got an=%h seg=%b frame=%b exp an=%h seg=%b frame=%b",
                 cyc, an_o, seg_o, frame_o, exp_an, SEG_4321[slot_of(cyc)], cyc % 32 == 0);
      end
      if (cyc == 40) enable_i = 1'b0;
      if (cyc == 60) enable_i = 1'b1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    digits_i   = '0;
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;
    test_reset();
    test_scan();
    test_snapshot();
    test_blanking();
    test_invalid();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
